gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe: RTL and testbench
=======================================================

GF180MCU_FD_SC_MCU7T5V0__OAI_NM_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe

Interface
REQ-001 SHALL have parameter CH, default 2, meaning the number of independent channels (1..8).
REQ-002 SHALL have parameter G, default 3, meaning the number of input groups per channel (2..4).
REQ-003 SHALL have parameter N, default 3, meaning the number of inputs per group (2..4).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port IN, input, CH*G*N bits: channel c, group g, bit n sits at index c*G*N + g*N + n.
REQ-007 SHALL have port MODE, input, 2 bits: 00 OAI, 01 AOI, 10 OA (non-inverted), 11 AO (non-inverted).
REQ-008 SHALL have port IN_VALID, input, 1 bit: IN and MODE are valid.
REQ-009 SHALL have port IN_READY, output, 1 bit: the block accepts IN and MODE this cycle.
REQ-010 SHALL have port ZN, output, CH bits: the per-channel result.
REQ-011 SHALL have port OUT_VALID, output, 1 bit: ZN is valid.
REQ-012 SHALL have port OUT_READY, input, 1 bit: the consumer accepts ZN.
REQ-013 SHALL have port CLR, input, 1 bit: synchronous clear of TOG_CNT.
REQ-014 SHALL have port TOG_CNT, output, 16 bits: count of output transfers where ZN changed.

Function
REQ-015 SHALL transfer an input when IN_VALID && IN_READY, and an output when OUT_VALID && OUT_READY.
REQ-016 SHALL implement stage 1 as registered group terms plus registered MODE.
- OAI/OA: reduce each group by OR.
- AOI/AO: reduce each group by AND.
- Stage 1 holds a valid bit v1.
REQ-017 SHALL implement stage 2 as the registered channel result, with valid bit v2.
- OAI: ~AND of groups. OA: AND of groups.
- AOI: ~OR of groups. AO: OR of groups.
REQ-018 SHALL drive OUT_VALID = v2 and ZN = the stage-2 data register.
REQ-019 SHALL have a latency of exactly 2 cycles, from the input transfer edge to OUT_VALID high, when there is no backpressure.
REQ-020 SHALL sustain 1 transfer per cycle while OUT_READY is held high.
REQ-021 SHALL compute readiness as follows:
- s2_ready = !v2 || OUT_READY.
- s1_ready = !v1 || s2_ready.
- IN_READY = s1_ready. IN_READY may depend combinationally on OUT_READY.
REQ-022 SHALL advance stage 1 into stage 2 when v1 && s2_ready; v1 holds otherwise.
REQ-023 SHALL hold ZN and OUT_VALID stable while OUT_VALID && !OUT_READY, and SHALL lose or duplicate no data.
REQ-024 SHALL apply MODE per transfer: a MODE change between transfers affects only later transfers.
REQ-025 SHALL keep a register LAST_ZN (reset 0) that updates on each output transfer.
REQ-026 SHALL increment TOG_CNT on an output transfer where ZN != LAST_ZN, and SHALL saturate it at 0xFFFF.
REQ-027 SHALL let CLR take priority over an increment in the same cycle, giving TOG_CNT = 0.
REQ-028 SHALL ignore IN when IN_VALID is low; IN may be X then.

Reset
REQ-029 SHALL, while RST = 1 at a clock edge, clear v1, v2, ZN, LAST_ZN and TOG_CNT to 0.
REQ-030 SHALL drive OUT_VALID = 0 and IN_READY = 1 from the first edge after RST is asserted.
REQ-031 SHALL discard any data in flight when RST is asserted mid-stream, with no output transfer for it.
REQ-032 SHALL give RST priority over CLR, IN_VALID and OUT_READY.

Verification (CH=2, G=3, N=3)
REQ-033 SHALL cover OAI: MODE=00, IN=18'h000A1 (ch0 groups 001/100/010, ch1 all 0), OUT_READY=1 -> ZN=2'b10, OUT_VALID high 2 cycles after acceptance.
REQ-034 SHALL cover AOI: MODE=01, IN=18'h001FF (ch0 groups all 111) -> ZN=2'b10; MODE=11 with the same IN -> ZN=2'b01.
REQ-035 SHALL cover backpressure: 4 back-to-back transfers with OUT_READY=0 for 3 cycles.
- IN_READY falls after 2 accepted transfers.
- All 4 results emerge in order, unchanged.
REQ-036 SHALL cover the toggle counter: alternate ZN between 2'b00 and 2'b11 across 5 output transfers.
- TOG_CNT=4, since the first ZN=00 matches the reset value of LAST_ZN.
- Assert CLR together with a toggle -> TOG_CNT=0.
REQ-037 SHALL cover saturation: preload TOG_CNT to 0xFFFE via toggles or force, then 3 toggles -> TOG_CNT=0xFFFF.
REQ-038 SHALL cover reset mid-stream: RST for 1 cycle with v1=v2=1.
- Next cycle: OUT_VALID=0, TOG_CNT=0, IN_READY=1.
- No stale ZN transfer afterwards.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe.sv
// Two-stage pipelined multi-channel OAI/AOI/OA/AO gate with a valid/ready interface
// and a saturating counter of output transfers whose result differs from the previous one.
module gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe #(
  parameter int CH = 2,
  parameter int G  = 3,
  parameter int N  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CH*G*N-1:0] IN,
  input  logic [1:0]        MODE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [CH-1:0]     ZN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  input  logic              CLR,
  output logic [15:0]       TOG_CNT
);

  // Handshake: a transfer happens on an edge where valid && ready; a producer holds
  // valid and data until that edge, and ready may depend combinationally on the
  // downstream ready, but valid never depends on ready.

  localparam int NG = CH * G;

  logic [NG-1:0] grp_d, grp_q;
  logic [1:0]    mode_d, mode_q;
  logic          v1_d, v1_q;
  logic [CH-1:0] zn_d, zn_q;
  logic          v2_d, v2_q;
  logic [CH-1:0] last_zn_d, last_zn_q;
  logic [15:0]   tog_cnt_d, tog_cnt_q;

  logic [NG-1:0] grp_terms;
  logic [CH-1:0] chan_res;
  logic          s2_ready;
  logic          s1_ready;
  logic          in_fire;
  logic          adv;
  logic          out_fire;

  assign s2_ready = !v2_q || OUT_READY;
  assign s1_ready = !v1_q || s2_ready;
  assign in_fire  = IN_VALID && s1_ready;
  assign adv      = v1_q && s2_ready;
  assign out_fire = v2_q && OUT_READY;

  // MODE[0] selects AND-first (AOI/AO) versus OR-first (OAI/OA) group reduction.
  always_comb begin
    grp_terms = '0;
    for (int c = 0; c < CH; c++) begin
      for (int g = 0; g < G; g++) begin
        if (MODE[0]) grp_terms[c*G + g] = &IN[(c*G + g)*N +: N];
        else         grp_terms[c*G + g] = |IN[(c*G + g)*N +: N];
      end
    end
  end

  // MODE[1] set means the non-inverted variant.
  always_comb begin
    chan_res = '0;
    for (int c = 0; c < CH; c++) begin
      if (mode_q[0]) chan_res[c] = |grp_q[c*G +: G];
      else           chan_res[c] = &grp_q[c*G +: G];
      if (!mode_q[1]) chan_res[c] = !chan_res[c];
    end
  end

  always_comb begin
    grp_d     = grp_q;
    mode_d    = mode_q;
    v1_d      = v1_q;
    zn_d      = zn_q;
    v2_d      = v2_q;
    last_zn_d = last_zn_q;
    tog_cnt_d = tog_cnt_q;

    if (in_fire) begin
      grp_d  = grp_terms;
      mode_d = MODE;
      v1_d   = 1'b1;
    end else if (adv) begin
      v1_d = 1'b0;
    end

    if (adv) begin
      zn_d = chan_res;
      v2_d = 1'b1;
    end else if (out_fire) begin
      v2_d = 1'b0;
    end

    if (out_fire) begin
      last_zn_d = zn_q;
      if (zn_q != last_zn_q && tog_cnt_q != 16'hFFFF) tog_cnt_d = tog_cnt_q + 16'd1;
    end
    if (CLR) tog_cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      grp_q     <= '0;
      mode_q    <= '0;
      v1_q      <= 1'b0;
      zn_q      <= '0;
      v2_q      <= 1'b0;
      last_zn_q <= '0;
      tog_cnt_q <= '0;
    end else begin
      grp_q     <= grp_d;
      mode_q    <= mode_d;
      v1_q      <= v1_d;
      zn_q      <= zn_d;
      v2_q      <= v2_d;
      last_zn_q <= last_zn_d;
      tog_cnt_q <= tog_cnt_d;
    end
  end

  assign IN_READY  = s1_ready;
  assign ZN        = zn_q;
  assign OUT_VALID = v2_q;
  assign TOG_CNT   = tog_cnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe.sv
// Bench for the pipelined OAI/AOI block: directed scenarios plus random traffic,
// scored against an in-order result queue computed from the gate equations.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe;
  localparam int CH = 2;
  localparam int G  = 3;
  localparam int N  = 3;
  localparam int W  = CH * G * N;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_bus;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [CH-1:0] zn;
  logic          out_valid;
  logic          out_ready;
  logic          clr;
  logic [15:0]   tog_cnt;

  gf180mcu_fd_sc_mcu7t5v0__oai_nm_pipe #(.CH(CH), .G(G), .N(N)) dut (
    .CLK(clk), .RST(rst), .IN(in_bus), .MODE(mode), .IN_VALID(in_valid),
    .IN_READY(in_ready), .ZN(zn), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .CLR(clr), .TOG_CNT(tog_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [CH-1:0] exp_q[$];
  logic [CH-1:0] exp_last;
  logic [15:0]   exp_tog;
  int            n_cmp;
  int            n_err;

  localparam logic [W-1:0] ALL0 = '0;
  localparam logic [W-1:0] ALL1 = '1;

  // Gate function from counting ones: a group is "hit" when all (AND) or any (OR) inputs are 1.
  function automatic logic [CH-1:0] ref_zn(input logic [W-1:0] din, input logic [1:0] md);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int hits;
      logic res;
      hits = 0;
      for (int g = 0; g < G; g++) begin
        int ones;
        ones = 0;
        for (int n = 0; n < N; n++) ones += int'(din[c*G*N + g*N + n]);
        if (md[0] ? (ones == N) : (ones > 0)) hits++;
      end
      res = md[0] ? (hits > 0) : (hits == G);
      r[c] = md[1] ? res : !res;
    end
    return r;
  endfunction

  // driver: one clock cycle; returns DUT samples and the model's view of this cycle
  task automatic tick(input logic iv, input logic [W-1:0] din, input logic [1:0] md,
                      input logic ordy, input logic cl, input logic rs,
                      output logic in_f, output logic out_f, output logic rdy_s,
                      output logic ov_s, output logic [CH-1:0] zn_s,
                      output logic [CH-1:0] exp_s, output logic exp_rdy);
    @(negedge clk);
    in_valid = iv; in_bus = iv ? din : 'x; mode = md; out_ready = ordy; clr = cl; rst = rs;
    #1;
    rdy_s = in_ready; ov_s = out_valid; zn_s = zn;
    in_f = in_valid && in_ready;
    out_f = out_valid && out_ready;
    exp_rdy = (exp_q.size() < 2) || ordy;
    exp_s = 'x;
    if (rs) begin
      exp_q.delete(); exp_last = '0; exp_tog = '0;
    end else begin
      if (out_f) begin
        if (exp_q.size() > 0) exp_s = exp_q.pop_front();
        if (exp_s !== exp_last && exp_tog != 16'hFFFF) exp_tog = exp_tog + 16'd1;
        exp_last = exp_s;
      end
      if (cl) exp_tog = '0;
      if (in_f) exp_q.push_back(ref_zn(din, md));
    end
    @(posedge clk);
    #1;
  endtask

  logic          t_in, t_out, t_rdy, t_ov, t_erdy;
  logic [CH-1:0] t_zn, t_exp;

  task automatic drain(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, ALL0, 2'b00, 1'b1, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
      if (t_out) begin
        n_cmp++;
        if (t_zn !== t_exp) begin n_err++; $display("FAIL %s_drain_zn: got %b expected %b", tag, t_zn, t_exp); end
      end
    end
  endtask

  task automatic test_reset();
    tick(1'b0, ALL0, 2'b00, 1'b0, 1'b0, 1'b1, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    tick(1'b0, ALL0, 2'b00, 1'b0, 1'b0, 1'b1, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (zn !== 2'b00) begin n_err++; $display("FAIL reset_zn: got %b expected 00", zn); end
    n_cmp++; if (tog_cnt !== 16'h0) begin n_err++; $display("FAIL reset_tog_cnt: got %h expected 0000", tog_cnt); end
  endtask

  // one directed item: accept, check 2-edge latency and the constant result
  task automatic directed(input string tag, input logic [W-1:0] din, input logic [1:0] md,
                          input logic [CH-1:0] want);
    tick(1'b1, din, md, 1'b1, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (t_in !== 1'b1) begin n_err++; $display("FAIL %s_accept: got %b expected 1", tag, t_in); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_valid: got %b expected 0", tag, out_valid); end
    tick(1'b0, ALL0, md, 1'b0, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency: got %b expected 1", tag, out_valid); end
    n_cmp++; if (zn !== want) begin n_err++; $display("FAIL %s_zn: got %b expected %b", tag, zn, want); end
    tick(1'b0, ALL0, md, 1'b1, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (t_out !== 1'b1 || t_zn !== t_exp) begin n_err++; $display("FAIL %s_model: got %b/%b expected 1/%b", tag, t_out, t_zn, t_exp); end
  endtask

  task automatic test_gates();
    directed("oai", 18'h000A1, 2'b00, 2'b10);
    directed("aoi", 18'h001FF, 2'b01, 2'b10);
    directed("ao",  18'h001FF, 2'b11, 2'b01);
    directed("oa",  18'h001FF, 2'b10, 2'b01);
  endtask

  task automatic test_backpressure();
    int acc, outs;
    logic [W-1:0] items[4];
    drain("bp");
    for (int i = 0; i < 4; i++) items[i] = W'($urandom());
    acc = 0; outs = 0;
    for (int cyc = 0; cyc < 30 && outs < 4; cyc++) begin
      tick(acc < 4, items[acc % 4], 2'b00, cyc >= 3, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
      if (cyc == 2) begin
        n_cmp++; if (t_rdy !== 1'b0 || acc != 2) begin n_err++; $display("FAIL bp_in_ready_low: got rdy=%b acc=%0d expected rdy=0 acc=2", t_rdy, acc); end
      end
      if (t_in) acc++;
      if (t_out) begin
        outs++;
        n_cmp++; if (t_zn !== t_exp) begin n_err++; $display("FAIL bp_order_zn: got %b expected %b", t_zn, t_exp); end
      end
    end
    n_cmp++; if (outs != 4) begin n_err++; $display("FAIL bp_count: got %0d expected 4", outs); end
  endtask

  task automatic test_random();
    logic prev_stall;
    logic [CH-1:0] prev_zn;
    drain("rnd");
    prev_stall = 1'b0; prev_zn = '0;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), W'($urandom()), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0), 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
      n_cmp++; if (t_rdy !== t_erdy) begin n_err++; $display("FAIL rnd_in_ready: got %b expected %b", t_rdy, t_erdy); end
      if (prev_stall) begin
        n_cmp++; if (t_ov !== 1'b1 || t_zn !== prev_zn) begin n_err++; $display("FAIL rnd_hold: got %b/%b expected 1/%b", t_ov, t_zn, prev_zn); end
      end
      if (t_out) begin
        n_cmp++; if (t_zn !== t_exp) begin n_err++; $display("FAIL rnd_zn: got %b expected %b", t_zn, t_exp); end
      end
      prev_stall = t_ov && !t_out;
      prev_zn = t_zn;
    end
    drain("rnd");
    n_cmp++; if (tog_cnt !== exp_tog) begin n_err++; $display("FAIL rnd_tog_cnt: got %h expected %h", tog_cnt, exp_tog); end
  endtask

  task automatic test_toggle();
    test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, (i % 2 == 1) ? ALL1 : ALL0, 2'b11, 1'b1, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
      if (t_out) begin
        n_cmp++; if (t_zn !== t_exp) begin n_err++; $display("FAIL tog_zn: got %b expected %b", t_zn, t_exp); end
      end
    end
    drain("tog");
    n_cmp++; if (tog_cnt !== 16'd4) begin n_err++; $display("FAIL tog_cnt_4: got %0d expected 4", tog_cnt); end
    tick(1'b1, ALL1, 2'b11, 1'b0, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    tick(1'b0, ALL0, 2'b11, 1'b0, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (out_valid !== 1'b1 || zn !== 2'b11) begin n_err++; $display("FAIL tog_pending: got %b/%b expected 1/11", out_valid, zn); end
    tick(1'b0, ALL0, 2'b11, 1'b1, 1'b1, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (tog_cnt !== 16'd0) begin n_err++; $display("FAIL tog_clr: got %0d expected 0", tog_cnt); end
  endtask

  task automatic test_saturation();
    int acc, post;
    logic hit;
    test_reset();
    acc = 0; hit = 1'b0; post = 0;
    for (int cyc = 0; cyc < 70000 && post < 3; cyc++) begin
      tick(1'b1, (acc % 2 == 0) ? ALL1 : ALL0, 2'b11, 1'b1, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
      if (t_in) acc++;
      if (t_out && t_zn !== t_exp) begin
        n_cmp++; n_err++; $display("FAIL sat_zn: got %b expected %b", t_zn, t_exp);
      end
      if (hit && t_out) post++;
      if (!hit && exp_tog == 16'hFFFE) begin
        hit = 1'b1;
        n_cmp++; if (tog_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_preload: got %h expected fffe", tog_cnt); end
      end
    end
    n_cmp++; if (!hit || post != 3) begin n_err++; $display("FAIL sat_timeout: got hit=%b post=%0d expected hit=1 post=3", hit, post); end
    n_cmp++; if (tog_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt: got %h expected ffff", tog_cnt); end
  endtask

  task automatic test_reset_midstream();
    drain("mid");
    tick(1'b1, ALL1, 2'b11, 1'b0, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    tick(1'b1, ALL0, 2'b11, 1'b0, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: got ov=%b rdy=%b expected ov=1 rdy=0", out_valid, in_ready); end
    tick(1'b1, ALL1, 2'b11, 1'b0, 1'b1, 1'b1, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (tog_cnt !== 16'h0) begin n_err++; $display("FAIL mid_tog_cnt: got %h expected 0000", tog_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, ALL0, 2'b11, 1'b1, 1'b0, 1'b0, t_in, t_out, t_rdy, t_ov, t_zn, t_exp, t_erdy);
      n_cmp++; if (t_out !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %b expected 0", t_out); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    exp_last = '0; exp_tog = '0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bus = '0; mode = 2'b00; out_ready = 1'b0;
    test_reset();
    test_gates();
    test_backpressure();
    test_random();
    test_toggle();
    test_saturation();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
